// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants, limb-product type and limb-count helper for mult
package mult_pkg;

    // Default operand/result width and limb width.
    localparam int N_DEF = 256;
    localparam int W_DEF = 32;

    // Number of limbs per operand at the default widths.
    localparam int M = N_DEF / W_DEF;

    // One W x W partial product at the default limb width.
    typedef logic [2*W_DEF-1:0] limb_prod_t;

    // Number of W-bit limbs in an n-bit operand.
    function automatic int limb_count(input int n, input int w);
        return n / w;
    endfunction

endpackage

// File: rtl/mult_limb.sv
// rtl/mult_limb.sv - registered W x W unsigned limb multiplier
//
// Ports:
//   clk  - rising-edge clock
//   rstn - asynchronous active-low reset, clears the product register
//   a, b - W-bit unsigned limbs
//   p    - 2W-bit registered product a*b
module mult_limb #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    logic [2*W-1:0] p_d;
    logic [2*W-1:0] p_q;

    // Zero-extend both limbs so the multiply is evaluated at full 2W width.
    always_comb begin
        p_d = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: rtl/mult.sv
// rtl/mult.sv - two-stage pipelined unsigned multiplier, Z = (X*Y) mod 2^N
//
// Ports:
//   clk  - rising-edge clock
//   rstn - asynchronous active-low reset, clears both pipeline stages
//   X, Y - N-bit unsigned operands, sampled every rising edge
//   Z    - N-bit registered low half of X*Y, two edges after sampling
module mult
    import mult_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    output logic [N-1:0] Z
);

    localparam int LM = limb_count(N, W);
    localparam int PW = 2 * W;

    generate
        if ((W < 1) || ((N % W) != 0)) begin : g_bad_width
            $error("mult: N must be a positive multiple of W");
        end
    endgenerate

    // Stage 1: limb products, flattened as entry (i*LM + j). Entries with
    // i+j >= LM only touch bits at or above N, so no multiplier is built for
    // them and their slot is tied to zero; the accumulation then shifts them
    // out of range anyway.
    logic [LM*LM*PW-1:0] pp;

    generate
        for (genvar i = 0; i < LM; i++) begin : g_row
            for (genvar j = 0; j < LM; j++) begin : g_col
                if (i + j < LM) begin : g_limb
                    mult_limb #(
                        .W (W)
                    ) u_limb (
                        .clk  (clk),
                        .rstn (rstn),
                        .a    (X[i*W +: W]),
                        .b    (Y[j*W +: W]),
                        .p    (pp[(i*LM + j)*PW +: PW])
                    );
                end else begin : g_none
                    assign pp[(i*LM + j)*PW +: PW] = '0;
                end
            end
        end
    endgenerate

    // Stage 2: shifted accumulation of all limb products, truncated to N bits.
    logic [N-1:0] z_d;
    logic [N-1:0] z_q;
    logic [N-1:0] term;

    always_comb begin
        z_d  = '0;
        term = '0;
        for (int i = 0; i < LM; i++) begin
            for (int j = 0; j < LM; j++) begin
                term = N'(pp[(i*LM + j)*PW +: PW]);
                z_d  = z_d + (term << ((i + j) * W));
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            z_q <= '0;
        end else begin
            z_q <= z_d;
        end
    end

    assign Z = z_q;

endmodule

// File: tb/tb_mult.sv
// tb/tb_mult.sv - randomized self-checking bench for mult against a plain-arithmetic product model
module tb_mult;

    localparam int N = 256;
    localparam int W = 32;

    logic         clk;
    logic         rstn;
    logic [N-1:0] X;
    logic [N-1:0] Y;
    logic [N-1:0] Z;

    int checks;
    int errors;

    // Reference: values expected in Z and in the first stage after each edge.
    logic [N-1:0] exp_z;
    logic [N-1:0] exp_s1;

    mult #(
        .N (N),
        .W (W)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .X    (X),
        .Y    (Y),
        .Z    (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] golden(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-1:0] full;
        full = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        return full[N-1:0];
    endfunction

    function automatic logic [N-1:0] rand_n();
        logic [N-1:0] r;
        for (int k = 0; k < N/32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Advance one rising edge, update the model, return at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!rstn) begin
            exp_z  = '0;
            exp_s1 = '0;
        end else begin
            exp_z  = exp_s1;
            exp_s1 = golden(X, Y);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        X = '1;
        Y = '1;
        exp_z = '0;
        exp_s1 = '0;
        #1;
        checks++;
        if (Z !== '0) begin
            errors++;
            $display("FAIL reset_immediate: Z=%h expected 0", Z);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (Z !== '0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: Z=%h expected 0", c, Z);
            end
        end
        X = '0;
        Y = '0;
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (Z !== '0 || exp_z !== '0) begin
                errors++;
                $display("FAIL reset_release cycle %0d: Z=%h expected 0", c, Z);
            end
        end
    endtask

    task automatic test_small();
        X = 256'd3;
        Y = 256'd5;
        tick();
        checks++;
        if (Z === 256'd15 || Z !== exp_z) begin
            errors++;
            $display("FAIL small_early: Z=%h expected %h (not yet 15)", Z, exp_z);
        end
        X = '0;
        Y = '0;
        tick();
        checks++;
        if (Z !== 256'd15) begin
            errors++;
            $display("FAIL small_result: Z=%h expected %h", Z, 256'd15);
        end
    endtask

    task automatic test_wrap();
        logic [N-1:0] xs [3];
        logic [N-1:0] ys [3];
        logic [N-1:0] zs [3];
        logic [N-1:0] one;
        one = 1;
        xs[0] = '1;             ys[0] = '1;                 zs[0] = one;
        xs[1] = one << (N-1);   ys[1] = 256'd2;             zs[1] = '0;
        xs[2] = one << (N/2);   ys[2] = one << (N/2 - 1);   zs[2] = one << (N-1);
        for (int t = 0; t < 3; t++) begin
            X = xs[t];
            Y = ys[t];
            tick();
            tick();
            checks++;
            if (Z !== zs[t]) begin
                errors++;
                $display("FAIL wrap_%0d: Z=%h expected %h", t, Z, zs[t]);
            end
        end
    endtask

    task automatic test_limb_carry();
        logic [N-1:0] one;
        logic [N-1:0] want;
        one = 1;
        X = (one << W) - one;
        Y = (one << W) + one;
        want = (one << (2*W)) - one;
        tick();
        tick();
        checks++;
        if (Z !== want) begin
            errors++;
            $display("FAIL limb_carry: Z=%h expected %h", Z, want);
        end
        X = '0;
        Y = rand_n();
        tick();
        tick();
        checks++;
        if (Z !== '0) begin
            errors++;
            $display("FAIL zero_operand: Z=%h expected 0", Z);
        end
    endtask

    // One result check per cycle; pulses reset between edges at two points,
    // the second one held across an edge.
    task automatic test_back_to_back();
        for (int c = 0; c < 10000; c++) begin
            checks++;
            if (Z !== exp_z) begin
                errors++;
                $display("FAIL stream cycle %0d: Z=%h expected %h", c, Z, exp_z);
            end
            X = rand_n();
            Y = rand_n();
            if (c == 4000 || c == 7000) begin
                #2;
                rstn = 1'b0;
                exp_z = '0;
                exp_s1 = '0;
                #1;
                checks++;
                if (Z !== '0) begin
                    errors++;
                    $display("FAIL midreset_async cycle %0d: Z=%h expected 0", c, Z);
                end
                if (c == 7000) tick();
                #1;
                rstn = 1'b1;
                tick();
                checks++;
                if (Z !== '0) begin
                    errors++;
                    $display("FAIL midreset_flush cycle %0d: Z=%h expected 0", c, Z);
                end
            end else begin
                tick();
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        void'($urandom(32'd20240611));
        test_reset();
        test_small();
        test_wrap();
        test_limb_carry();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
